// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for the JK modulo counter.
// The counter is the slave; the driver of en/up/load/din is the master.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic [7:0]       wrap_cnt;

  modport master (
    output en, up, load, din,
    input  q, tc, wrap, wrap_cnt
  );

  modport slave (
    input  en, up, load, din,
    output q, tc, wrap, wrap_cnt
  );
endinterface

// File: rtl/jk_mod_counter.sv
// Up/down modulo counter built from per-bit JK flip-flop equations,
// with parallel load, wrap pulse and saturating wrap counter.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic              clk,
  input logic              reset,
  jk_mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] tgt, din_c;
  logic             wrap_q, wrap_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             at_max, at_zero;
  logic             wrap_step;

  always_comb begin
    at_max  = (q_q == MAX);
    at_zero = (q_q == '0);
    din_c   = ({1'b0, bus.din} < MODW) ? bus.din : MAX;
    if (bus.up) tgt = at_max ? '0 : q_q + 1'b1;
    else        tgt = at_zero ? MAX : q_q - 1'b1;
    wrap_step = bus.en & ~bus.load & (bus.up ? at_max : at_zero);
    j = '0;
    k = '0;
    // count steps toggle exactly the bits that differ from the target
    if (bus.load) begin
      j = din_c;
      k = ~din_c;
    end else if (bus.en) begin
      j = q_q ^ tgt;
      k = q_q ^ tgt;
    end
    q_d    = (j & ~q_q) | (~k & q_q);
    wrap_d = wrap_step;
    cnt_d  = cnt_q;
    if (wrap_step && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.tc       = wrap_step;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = cnt_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed and random bench for jk_mod_counter against an
// arithmetic reference model.
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int   q_m = 0;
  bit   wrap_m = 0;
  int   cnt_m = 0;
  bit   known = 0;

  jk_mod_counter_if #(.WIDTH(W)) bus ();

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u,
                      input bit l, input int d);
    bit tc_m;
    int nq;
    bit wr;
    reset    = r;
    bus.en   = e;
    bus.up   = u;
    bus.load = l;
    bus.din  = W'(d);
    #1;
    if (known) begin
      tc_m = e && !l && ((u && q_m == M-1) || (!u && q_m == 0));
      chk("tc", int'(bus.tc), int'(tc_m));
    end
    @(posedge clk);
    if (!r) begin
      q_m = 0; wrap_m = 0; cnt_m = 0; known = 1;
    end else if (l) begin
      q_m = (d < M) ? d : M-1;
      wrap_m = 0;
    end else if (e) begin
      nq = u ? q_m + 1 : q_m - 1;
      wr = (nq >= M) || (nq < 0);
      q_m = (nq + M) % M;
      wrap_m = wr;
      if (wr && cnt_m < 255) cnt_m++;
    end else begin
      wrap_m = 0;
    end
    #1;
    if (known) begin
      chk("q", int'(bus.q), q_m);
      chk("wrap", int'(bus.wrap), int'(wrap_m));
      chk("wrap_cnt", int'(bus.wrap_cnt), cnt_m);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.din = '0;

    // reset overrides load and en
    step(0, 1, 1, 1, 5);
    step(0, 1, 1, 1, 5);
    chk("rst_q", int'(bus.q), 0);

    // up count across wrap
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
    chk("up12_q", int'(bus.q), 2);
    chk("up12_cnt", int'(bus.wrap_cnt), 1);

    // down from zero
    step(1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0);
    chk("dn_q9", int'(bus.q), 9);
    chk("dn_wrap", int'(bus.wrap), 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("dn_q7", int'(bus.q), 7);
    chk("dn_cnt", int'(bus.wrap_cnt), 2);

    // load with clamp
    step(1, 1, 1, 1, 13);
    chk("clamp_q", int'(bus.q), 9);
    step(1, 1, 1, 1, 3);
    chk("load_q", int'(bus.q), 3);

    // hold then reset mid-count
    step(1, 0, 1, 1, 4);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
    chk("hold_q", int'(bus.q), 4);
    step(1, 0, 1, 1, 9);
    step(0, 1, 1, 0, 0);
    chk("rst9_q", int'(bus.q), 0);
    chk("rst9_wrap", int'(bus.wrap), 0);
    step(1, 1, 1, 0, 0);
    chk("post_rst_q", int'(bus.q), 1);

    // saturation of wrap counter
    for (int i = 0; i < 3000; i++) step(1, 1, 1, 0, 0);
    chk("sat_cnt", int'(bus.wrap_cnt), 255);
    chk("sat_q", int'(bus.q), 1);

    // random mix
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
